uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 (or 8E1) serial receiver with a one-deep output register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined : 8N1 framing, parity_err is tied low
//   defined   : 8E1 framing, even-parity bit checked between data and stop
//
// Parameters
//   CLKS_PER_BIT : hwclk cycles per serial bit (>= 4), default 12 MHz / 9600
// Ports
//   hwclk      : clock, all flops rising-edge
//   rst_n      : synchronous active-low reset
//   ftdi_rx    : asynchronous serial input, idle high, LSB first
//   rx_data    : last accepted byte
//   rx_valid   : rx_data holds a byte not yet taken by the consumer
//   rx_ready   : consumer takes the byte when rx_valid is also high
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, completed byte dropped (output still full)
//   parity_err : one-cycle pulse, parity bit mismatch (parity build only)
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       ftdi_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, WAIT_IDLE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, WAIT_IDLE = 3'd5
  } state_t;
`endif

  // Even parity of a data byte: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic          sync1_r, sync2_r, prev_r;
  logic          rx_s, fall_s, tick_s;
  state_t        state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic [2:0]    bit_idx_r, bit_idx_nx_s;
  logic [7:0]    shift_r, shift_nx_s;
  logic          done_s, frame_err_s;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_r, par_bad_nx_s, parity_err_s;
`endif

  assign rx_s   = sync2_r;
  assign fall_s = prev_r & ~sync2_r;
  assign tick_s = (cnt_r == CNT_ZERO);

  // Two-flop synchronizer plus a history flop for 1->0 edge detection; all reset high (idle line).
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= ftdi_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Next-state logic: bit timing, sampling, shifting and frame outcome strobes.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    bit_idx_nx_s = bit_idx_r;
    shift_nx_s   = shift_r;
    done_s       = 1'b0;
    frame_err_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx_s = par_bad_r;
    parity_err_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          // Half a bit lands the next samples in the middle of each bit.
          state_nx_s = START;
          cnt_nx_s   = CNT_HALF;
        end else begin
          cnt_nx_s = CNT_ZERO;
        end
      end
      START: begin
        if (tick_s) begin
          if (rx_s) begin
            state_nx_s = IDLE;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            state_nx_s   = DATA;
            cnt_nx_s     = CNT_FULL;
            bit_idx_nx_s = 3'd0;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_nx_s = {rx_s, shift_r[7:1]};
          cnt_nx_s   = CNT_FULL;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx_s = PARITY;
`else
            state_nx_s = STOP;
`endif
            bit_idx_nx_s = 3'd0;
          end else begin
            bit_idx_nx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          state_nx_s = STOP;
          cnt_nx_s   = CNT_FULL;
          if (rx_s != even_parity(shift_r)) begin
            parity_err_s = 1'b1;
            par_bad_nx_s = 1'b1;
          end else begin
            par_bad_nx_s = 1'b0;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          cnt_nx_s = CNT_ZERO;
          if (rx_s) begin
            state_nx_s = IDLE;
`ifdef UART_RX_PARITY_EN
            done_s = ~par_bad_r;
`else
            done_s = 1'b1;
`endif
          end else begin
            // Line held low past the stop bit: treat as break and wait it out.
            state_nx_s  = WAIT_IDLE;
            frame_err_s = 1'b1;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        cnt_nx_s = CNT_ZERO;
        if (rx_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM and datapath state registers.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      bit_idx_r <= bit_idx_nx_s;
      shift_r   <= shift_nx_s;
`ifdef UART_RX_PARITY_EN
      par_bad_r <= par_bad_nx_s;
`endif
    end
  end

  // Output register: load on completion if empty or draining this cycle, else flag overrun.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_err_s;
      overrun   <= 1'b0;
      if (done_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Registered parity failure strobe.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err_s;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
